ps2_rx_fifo: RTL and testbench
==============================

// Module: ps2_rx_fifo
// PURPOSE
//  Parametrised PS/2 device-to-host receiver, fully synchronous to the system clock.
//  - Oversamples PS2_CLK/PS2_DAT, filters glitches and checks start, odd parity and stop bits.
//  - Drops frames that stall, and buffers good scancodes in a FWFT FIFO with a valid/ready port.
//  - Sits between the keyboard pins and the CPU keyboard I/O register.
// PARAMETERS
//  SYNC_STAGES     2       synchroniser flops on PS2_CLK and PS2_DAT (>=2)
//  FILTER_LEN      8       consecutive equal samples needed to change filtered PS2_CLK (>=2)
//  TIMEOUT_CYCLES  50000   clk cycles without a filtered falling edge before a partial frame is aborted
//  FIFO_DEPTH      16      scancode FIFO entries; power of 2, >=2
// PORTS
//  clk         in   1                         system clock; all logic on posedge
//  rst_n       in   1                         synchronous, active-low reset
//  PS2_CLK     in   1                         raw PS/2 clock pin (asynchronous)
//  PS2_DAT     in   1                         raw PS/2 data pin (asynchronous)
//  scancode    out  8                         FIFO head byte; meaningful only when valid=1
//  valid       out  1                         FIFO not empty
//  ready       in   1                         consumer pops the head when valid & ready
//  level       out  $clog2(FIFO_DEPTH)+1      current FIFO occupancy
//  busy        out  1                         FSM not in IDLE (frame in progress)
//  parity_err  out  1                         1-cycle pulse: frame had bad parity; frame discarded
//  frame_err   out  1                         1-cycle pulse: stop bit 0 or timeout; frame discarded
//  overflow    out  1                         1-cycle pulse: good frame dropped because FIFO full
// BEHAVIOUR
//  Reset (rst_n=0 at posedge clk):
//  - Synchroniser flops and filtered clock are set to 1.
//  - FSM goes to IDLE; shift register, bit counter and timeout counter are cleared; FIFO is emptied.
//  - All outputs read 0. scancode reads 0 while the FIFO is empty.
//  - A partially received frame is discarded with no error pulse.
//  Input conditioning:
//  - Each pin passes through SYNC_STAGES flops.
//  - Filtered clock takes a new value only when the last FILTER_LEN synchronised samples all equal it.
//  - Edge event: a 1->0 transition of the filtered clock, flagged for exactly one cycle.
//  - Data bit: the synchronised PS2_DAT value in the edge-event cycle.
//  - Latency from a clean pin fall to the edge event is SYNC_STAGES+FILTER_LEN cycles.
//  FSM (advances only on edge events, except timeout):
//  - IDLE: data=0 -> DATA with bit_cnt=0. data=1 -> stay IDLE (no error).
//  - DATA: shift data in LSB first. After the 8th bit -> PARITY.
//  - PARITY: capture the parity bit -> STOP.
//  - STOP: evaluated in the edge cycle, then -> IDLE.
//      stop=0                            -> frame_err
//      stop=1 and ^{data,parity}==0      -> parity_err
//      stop=1 and parity OK              -> push the byte
//  - Timeout counter clears on every edge event and holds 0 in IDLE.
//  - In non-IDLE states, if the counter reaches TIMEOUT_CYCLES-1 -> IDLE and frame_err pulses.
//  - Error flags pulse in the cycle after the deciding event.
//  FIFO (first-word fall-through):
//  - A push is registered at the end of the stop-bit edge cycle; valid/scancode update the next cycle.
//  - Pop on valid & ready; the next entry appears on the following cycle.
//  - Push and pop in the same cycle:
//      both succeed; level is unchanged
//      if full, the push is accepted because a pop occurs
//      if empty, only the push occurs
//  - Push while full with no pop: byte dropped, overflow pulses, FIFO contents unchanged.
//  - Read/write pointers wrap modulo FIFO_DEPTH; level saturates at FIFO_DEPTH by construction.
//  - ready while valid=0 has no effect.
// TESTING
//  1. Frame 0x1C, parity=0, stop=1, ready=1 -> valid pulses, scancode=0x1C, level 1->0, no error flags.
//  2. Frame 0xF0 with parity=0 (even total) -> parity_err pulses once, level stays 0, busy returns to 0.
//  3. Frame 0x5A, correct parity, stop=0 -> frame_err pulses, FIFO empty; next good 0x5A -> scancode=0x5A.
//  4. Stop PS2_CLK after 5 data bits -> frame_err pulses TIMEOUT_CYCLES after the last edge; then a full 0x29 frame is received.
//  5. ready=0, send 17 frames 0x01..0x11 -> level=16, overflow pulses on the 17th; pops return 0x01..0x10 in order.
//  6. 3-cycle low glitch on PS2_CLK in IDLE -> no edge, busy=0; rst_n=0 mid-frame -> busy=0, level=0, no error pulse.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronise and filter the pins, decode 11-bit frames
// (start, 8 data LSB first, odd parity, stop), and queue good scancodes in a FWFT FIFO.
module ps2_rx_fifo #(
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int FIFO_DEPTH     = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          PS2_CLK,
   input  logic                          PS2_DAT,
   output logic [7:0]                    scancode,
   output logic                          valid,
   input  logic                          ready,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          busy,
   output logic                          parity_err,
   output logic                          frame_err,
   output logic                          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [AW:0]   FULL_LVL = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   // Odd parity holds when data plus parity bit carry an odd number of ones
   function automatic logic parity_ok(input logic [7:0] d, input logic p);
      return ^{d, p};
   endfunction

   logic [SYNC_STAGES-1:0] clk_sync_r;
   logic [SYNC_STAGES-1:0] dat_sync_r;
   logic [FILTER_LEN-2:0]  hist_r;
   logic                   filt_r;
   logic                   edge_r;
   logic                   clk_s;
   logic                   dat_s;
   logic                   all0_s;
   logic                   all1_s;

   state_t                 state_r;
   logic [7:0]             shift_r;
   logic [2:0]             bit_cnt_r;
   logic                   parity_r;
   logic [TW-1:0]          tmo_r;
   logic                   busy_r;
   logic                   perr_r;
   logic                   ferr_r;
   logic                   push_s;

   logic [7:0]             mem_r [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr_r;
   logic [AW-1:0]          rd_ptr_r;
   logic [AW:0]            level_r;
   logic                   ovf_r;
   logic                   full_s;
   logic                   pop_s;
   logic                   wr_en_s;

   assign clk_s  = clk_sync_r[SYNC_STAGES-1];
   assign dat_s  = dat_sync_r[SYNC_STAGES-1];
   assign all0_s = (clk_s == 1'b0) && (hist_r == '0);
   assign all1_s = (clk_s == 1'b1) && (hist_r == '1);

   // Pin synchronisers and glitch filter; edge_r marks the filtered 1->0 transition
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         clk_sync_r <= '1;
         dat_sync_r <= '1;
         hist_r     <= '1;
         filt_r     <= 1'b1;
         edge_r     <= 1'b0;
      end else begin
         clk_sync_r <= {clk_sync_r[SYNC_STAGES-2:0], PS2_CLK};
         dat_sync_r <= {dat_sync_r[SYNC_STAGES-2:0], PS2_DAT};
         hist_r     <= {hist_r[FILTER_LEN-3 >= 0 ? FILTER_LEN-3 : 0:0], clk_s};
         edge_r     <= filt_r & all0_s;
         if (all1_s) begin
            filt_r <= 1'b1;
         end else if (all0_s) begin
            filt_r <= 1'b0;
         end
      end
   end

   assign push_s = edge_r && (state_r == STOP) && dat_s && parity_ok(shift_r, parity_r);

   // Frame decoder; the timeout abort takes priority over edge-driven progress
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         shift_r   <= 8'h00;
         bit_cnt_r <= 3'd0;
         parity_r  <= 1'b0;
         tmo_r     <= '0;
         busy_r    <= 1'b0;
         perr_r    <= 1'b0;
         ferr_r    <= 1'b0;
      end else begin
         perr_r <= 1'b0;
         ferr_r <= 1'b0;
         if ((state_r == IDLE) || edge_r) begin
            tmo_r <= '0;
         end else begin
            tmo_r <= tmo_r + TW'(1);
         end
         if ((state_r != IDLE) && !edge_r && (tmo_r == TMO_LAST)) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            ferr_r  <= 1'b1;
         end else if (edge_r) begin
            case (state_r)
               IDLE: begin
                  if (!dat_s) begin
                     state_r   <= DATA;
                     bit_cnt_r <= 3'd0;
                     busy_r    <= 1'b1;
                  end
               end
               DATA: begin
                  shift_r <= {dat_s, shift_r[7:1]};
                  if (bit_cnt_r == 3'd7) begin
                     state_r <= PARITY;
                  end else begin
                     bit_cnt_r <= bit_cnt_r + 3'd1;
                  end
               end
               PARITY: begin
                  parity_r <= dat_s;
                  state_r  <= STOP;
               end
               STOP: begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
                  if (!dat_s) begin
                     ferr_r <= 1'b1;
                  end else if (!parity_ok(shift_r, parity_r)) begin
                     perr_r <= 1'b1;
                  end
               end
               default: begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign full_s  = (level_r == FULL_LVL);
   assign pop_s   = (level_r != '0) && ready;
   assign wr_en_s = push_s && (!full_s || pop_s);

   // FIFO pointers and occupancy; a push into a full FIFO survives only alongside a pop
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         level_r  <= '0;
         ovf_r    <= 1'b0;
      end else begin
         ovf_r <= push_s && full_s && !pop_s;
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         if (wr_en_s && !pop_s) begin
            level_r <= level_r + (AW+1)'(1);
         end else if (!wr_en_s && pop_s) begin
            level_r <= level_r - (AW+1)'(1);
         end
      end
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r] <= shift_r;
      end
   end

   assign valid      = (level_r != '0);
   assign scancode   = valid ? mem_r[rd_ptr_r] : 8'h00;
   assign level      = level_r;
   assign busy       = busy_r;
   assign parity_err = perr_r;
   assign frame_err  = ferr_r;
   assign overflow   = ovf_r;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: directed frame table, corner-case sequences
// and randomized frames checked against a queue-based reference model.
module tb_ps2_rx_fifo;

   localparam int S = 2;
   localparam int F = 4;
   localparam int T = 300;
   localparam int D = 16;
   localparam int H = 12;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       PS2_CLK = 1'b1;
   logic       PS2_DAT = 1'b1;
   logic [7:0] scancode;
   logic       valid;
   logic       ready = 1'b1;
   logic [4:0] level;
   logic       busy;
   logic       parity_err;
   logic       frame_err;
   logic       overflow;

   ps2_rx_fifo #(.SYNC_STAGES(S), .FILTER_LEN(F), .TIMEOUT_CYCLES(T), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
      .scancode(scancode), .valid(valid), .ready(ready), .level(level), .busy(busy),
      .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;
   int pe_cnt, fe_cnt, ov_cnt, fe_cyc, lvl_max;
   bit busy_seen;
   logic [7:0] got_q[$];
   logic [7:0] model_q[$];

   always @(negedge clk) begin
      if (parity_err) pe_cnt++;
      if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
      if (overflow) ov_cnt++;
      if (valid && ready) got_q.push_back(scancode);
      if (int'(level) > lvl_max) lvl_max = int'(level);
      if (busy) busy_seen = 1'b1;
   end

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       stop;
      int         exp_pe;
      int         exp_fe;
      int         exp_cnt;
   } vec_t;

   vec_t tbl[10];

   task automatic check(input string nm, input int act, input int expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", nm, act, expv);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      pe_cnt = 0; fe_cnt = 0; ov_cnt = 0; fe_cyc = -1; lvl_max = 0; busy_seen = 1'b0;
      got_q.delete();
   endtask

   task automatic send_bits(input logic [10:0] bits, input int n, output int last_fall);
      last_fall = 0;
      for (int i = 0; i < n; i++) begin
         PS2_DAT = bits[i];
         tick(H);
         PS2_CLK = 1'b0;
         last_fall = cyc;
         tick(H);
         PS2_CLK = 1'b1;
      end
      tick(H);
      PS2_DAT = 1'b1;
   endtask

   function automatic logic [10:0] mk(input logic [7:0] d, input logic p, input logic s);
      return {s, p, d, 1'b0};
   endfunction

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
      int lf;
      send_bits(mk(d, p, s), 11, lf);
      tick(2 * H);
   endtask

   initial begin
      int lf;
      int exp_cnt;
      int exp_ov;
      logic [7:0] d;
      logic p, s, good;

      tbl[0] = '{8'h1C, 1'b0, 1'b1, 0, 0, 1};
      tbl[1] = '{8'hF0, 1'b0, 1'b1, 1, 0, 0};
      tbl[2] = '{8'h5A, 1'b1, 1'b0, 0, 1, 0};
      tbl[3] = '{8'h5A, 1'b1, 1'b1, 0, 0, 1};
      tbl[4] = '{8'h00, 1'b1, 1'b1, 0, 0, 1};
      tbl[5] = '{8'hFF, 1'b1, 1'b1, 0, 0, 1};
      tbl[6] = '{8'hFF, 1'b0, 1'b1, 1, 0, 0};
      tbl[7] = '{8'h80, 1'b0, 1'b1, 0, 0, 1};
      tbl[8] = '{8'h80, 1'b1, 1'b1, 1, 0, 0};
      tbl[9] = '{8'h3C, 1'b1, 1'b0, 0, 1, 0};

      clear_mon();
      tick(3);
      check("rst_valid", int'(valid), 0);
      check("rst_scancode", int'(scancode), 0);
      check("rst_level", int'(level), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_flags", int'({parity_err, frame_err, overflow}), 0);
      rst_n = 1'b1;
      tick(2 * F);

      // Directed frame table
      ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         clear_mon();
         send_frame(tbl[i].data, tbl[i].par, tbl[i].stop);
         check($sformatf("tbl%0d_perr", i), pe_cnt, tbl[i].exp_pe);
         check($sformatf("tbl%0d_ferr", i), fe_cnt, tbl[i].exp_fe);
         check($sformatf("tbl%0d_count", i), got_q.size(), tbl[i].exp_cnt);
         check($sformatf("tbl%0d_lvlmax", i), lvl_max, tbl[i].exp_cnt);
         check($sformatf("tbl%0d_busy_end", i), int'(busy), 0);
         if (got_q.size() == 1)
            check($sformatf("tbl%0d_byte", i), int'(got_q[0]), int'(tbl[i].data));
      end

      // Timeout after start plus five data bits
      clear_mon();
      send_bits(mk(8'h15, 1'b0, 1'b1), 6, lf);
      check("tmo_busy_mid", int'(busy), 1);
      for (int k = 0; k < T + 60 && fe_cnt == 0; k++) tick(1);
      check("tmo_ferr", fe_cnt, 1);
      check("tmo_late", int'(fe_cyc <= lf + S + F + T + 3), 1);
      check("tmo_early", int'(fe_cyc >= lf + S + F + T - 1), 1);
      check("tmo_busy_end", int'(busy), 0);
      clear_mon();
      send_frame(8'h29, 1'b0, 1'b1);
      check("tmo_next_count", got_q.size(), 1);
      if (got_q.size() == 1) check("tmo_next_byte", int'(got_q[0]), 8'h29);
      check("tmo_next_errs", pe_cnt + fe_cnt, 0);

      // Overflow: 17 frames with no consumer
      clear_mon();
      ready = 1'b0;
      for (int i = 1; i <= 17; i++) begin
         d = 8'(i);
         send_frame(d, ~^d, 1'b1);
      end
      check("ovf_level", int'(level), 16);
      check("ovf_pulses", ov_cnt, 1);
      check("ovf_head", int'(scancode), 8'h01);
      ready = 1'b1;
      tick(24);
      check("ovf_drain_count", got_q.size(), 16);
      for (int i = 0; i < got_q.size() && i < 16; i++)
         check($sformatf("ovf_pop%0d", i), int'(got_q[i]), i + 1);
      check("ovf_level_end", int'(level), 0);
      check("ovf_valid_end", int'(valid), 0);

      // Short clock glitch in IDLE
      clear_mon();
      PS2_CLK = 1'b0;
      tick(3);
      PS2_CLK = 1'b1;
      tick(30);
      check("glitch_busy", int'(busy_seen), 0);
      check("glitch_level", int'(level), 0);

      // Reset in the middle of a frame
      clear_mon();
      send_bits(mk(8'h33, 1'b1, 1'b1), 4, lf);
      check("mrst_busy_before", int'(busy), 1);
      rst_n = 1'b0;
      tick(2);
      check("mrst_busy", int'(busy), 0);
      check("mrst_level", int'(level), 0);
      rst_n = 1'b1;
      tick(T + 40);
      check("mrst_no_err", pe_cnt + fe_cnt + ov_cnt, 0);
      check("mrst_busy_after", int'(busy), 0);

      // Randomized frames against a queue model of decode rules and FIFO capacity
      model_q.delete();
      exp_ov = 0;
      clear_mon();
      for (int n = 0; n < 24; n++) begin
         d = 8'($urandom_range(0, 255));
         good = ($urandom_range(0, 3) != 0);
         p = good ? ~^d : ^d;
         s = ($urandom_range(0, 7) != 0);
         ready = ($urandom_range(0, 9) < 7);
         if (s && good) begin
            if (model_q.size() < D) model_q.push_back(d);
            else exp_ov++;
         end
         clear_mon();
         send_frame(d, p, s);
         check($sformatf("rnd%0d_ferr", n), fe_cnt, int'(!s));
         check($sformatf("rnd%0d_perr", n), pe_cnt, int'(s && !good));
         check($sformatf("rnd%0d_ovf", n), ov_cnt, exp_ov);
         exp_ov = 0;
         exp_cnt = ready ? model_q.size() : 0;
         check($sformatf("rnd%0d_pops", n), got_q.size(), exp_cnt);
         for (int i = 0; i < got_q.size() && i < exp_cnt; i++)
            check($sformatf("rnd%0d_byte%0d", n, i), int'(got_q[i]), int'(model_q[i]));
         if (ready) model_q.delete();
         check($sformatf("rnd%0d_level", n), int'(level), model_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
